// File: rtl/pcie_lane_serializer.sv
// Multi-lane parallel-to-serial converter for the TX PHY path. A one-deep hold register
// feeds a per-lane shifter so back-to-back symbols stream with no gap between them.
module pcie_lane_serializer #(
  parameter int unsigned DATA_WIDTH = 10,
  parameter int unsigned NUM_LANES  = 1,
  parameter bit          LSB_FIRST  = 1'b1,
  parameter logic        IDLE_BIT   = 1'b0
) (
  input  logic                            clk_i,
  input  logic                            rst_ni,
  input  logic                            tx_en_i,
  input  logic                            sym_valid_i,
  input  logic [NUM_LANES*DATA_WIDTH-1:0] sym_data_i,
  output logic                            sym_ready_o,
  output logic [NUM_LANES-1:0]            bit_o,
  output logic                            bit_valid_o,
  output logic                            sym_start_o,
  output logic                            underrun_o,
  output logic                            busy_o
);

  localparam int unsigned CntW    = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;
  localparam int unsigned BusW    = NUM_LANES * DATA_WIDTH;
  localparam int unsigned OutIdx  = LSB_FIRST ? 0 : DATA_WIDTH - 1;
  localparam logic [CntW-1:0] CntLast = CntW'(DATA_WIDTH - 1);

  typedef enum logic {StIdle, StShift} state_e;

  state_e            state_q, state_d;
  logic              hold_valid_q, hold_valid_d;
  logic [BusW-1:0]   hold_q, hold_d;
  logic [BusW-1:0]   shift_q, shift_d;
  logic [CntW-1:0]   cnt_q, cnt_d;
  logic              underrun_q, underrun_d;
  logic              last_bit;
  logic              load;
  logic              accept;

  assign last_bit    = (state_q == StShift) && (cnt_q == CntLast);
  assign load        = hold_valid_q && tx_en_i && ((state_q == StIdle) || last_bit);
  assign sym_ready_o = !hold_valid_q || load;
  assign accept      = sym_valid_i && sym_ready_o;

  always_comb begin
    hold_d       = hold_q;
    hold_valid_d = hold_valid_q;
    if (accept) begin
      hold_d       = sym_data_i;
      hold_valid_d = 1'b1;
    end else if (load) begin
      hold_valid_d = 1'b0;
    end
  end

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    shift_d    = shift_q;
    underrun_d = 1'b0;
    if (load) begin
      state_d = StShift;
      cnt_d   = '0;
      shift_d = hold_q;
    end else if (last_bit) begin
      // Shifter ran dry; only a starved (enabled) link counts as an underrun.
      state_d    = StIdle;
      cnt_d      = '0;
      underrun_d = tx_en_i;
    end else if (state_q == StShift) begin
      cnt_d = cnt_q + CntW'(1);
      for (int k = 0; k < int'(NUM_LANES); k++) begin
        shift_d[k*DATA_WIDTH +: DATA_WIDTH] = LSB_FIRST ?
            (shift_q[k*DATA_WIDTH +: DATA_WIDTH] >> 1) :
            (shift_q[k*DATA_WIDTH +: DATA_WIDTH] << 1);
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q      <= StIdle;
      hold_valid_q <= 1'b0;
      hold_q       <= '0;
      shift_q      <= '0;
      cnt_q        <= '0;
      underrun_q   <= 1'b0;
    end else begin
      state_q      <= state_d;
      hold_valid_q <= hold_valid_d;
      hold_q       <= hold_d;
      shift_q      <= shift_d;
      cnt_q        <= cnt_d;
      underrun_q   <= underrun_d;
    end
  end

  always_comb begin
    bit_o = {NUM_LANES{IDLE_BIT}};
    if (state_q == StShift) begin
      for (int k = 0; k < int'(NUM_LANES); k++) begin
        bit_o[k] = shift_q[k*DATA_WIDTH + OutIdx];
      end
    end
  end

  assign bit_valid_o = (state_q == StShift);
  assign sym_start_o = (state_q == StShift) && (cnt_q == '0);
  assign underrun_o  = underrun_q;
  assign busy_o      = hold_valid_q || (state_q == StShift);

endmodule
